// File: rtl/sync_fifo_param_if.sv
// sync_fifo_param_if: write/read handshake and status bus of sync_fifo_param
interface sync_fifo_param_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 8
);
  logic [DATA_W-1:0] din;
  logic [DATA_W-1:0] dout;
  logic              wr_en;
  logic              rd_en;
  logic              full;
  logic              almost_full;
  logic              wr_ack;
  logic              overflow;
  logic              empty;
  logic              almost_empty;
  logic              valid;
  logic              underflow;
  logic [ADDR_W:0]   data_count;
  logic              rst_busy;
  modport master (
    output din, wr_en, rd_en,
    input  dout, full, almost_full, wr_ack, overflow, empty, almost_empty,
           valid, underflow, data_count, rst_busy
  );
  modport slave (
    input  din, wr_en, rd_en,
    output dout, full, almost_full, wr_ack, overflow, empty, almost_empty,
           valid, underflow, data_count, rst_busy
  );
endinterface

// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock FIFO with status flags; define SYNC_FIFO_FWFT_EN for first-word-fall-through reads
module sync_fifo_param #(
  parameter int DATA_W          = 8,
  parameter int ADDR_W          = 8,
  parameter int AF_THRESH       = 2**ADDR_W - 2,
  parameter int AE_THRESH       = 2,
  parameter int RST_BUSY_CYCLES = 4
) (
  input logic             clk,
  input logic             rst,
  sync_fifo_param_if.slave f
);
  localparam int BW = $clog2(RST_BUSY_CYCLES + 1);
  localparam logic [ADDR_W:0] DEPTH = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0] AF = (ADDR_W+1)'(AF_THRESH);
  localparam logic [ADDR_W:0] AE = (ADDR_W+1)'(AE_THRESH);
  localparam logic [BW-1:0] BN = BW'(RST_BUSY_CYCLES);
  logic [DATA_W-1:0] mem [2**ADDR_W];
  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [ADDR_W:0]   count;
  logic [BW-1:0]     busy_cnt;
  logic              busy;
  logic              wr_req;
  logic              rd_req;
  logic              wr_acc;
  logic              rd_acc;
  assign wr_req = f.wr_en && !busy;
  assign rd_req = f.rd_en && !busy;
  assign wr_acc = wr_req && !f.full;
  assign rd_acc = rd_req && !f.empty;
  assign f.full = count == DEPTH || busy;
  assign f.almost_full = count >= AF || busy;
  assign f.empty = count == '0;
  assign f.almost_empty = count <= AE;
  assign f.data_count = count;
  assign f.rst_busy = busy;
  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b1;
      busy_cnt <= BN;
    end else if (busy) begin
      busy     <= busy_cnt != '0;
      busy_cnt <= busy_cnt != '0 ? busy_cnt - BW'(1) : busy_cnt;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      f.wr_ack    <= 1'b0;
      f.overflow  <= 1'b0;
      f.underflow <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr + ADDR_W'(wr_acc);
      rd_ptr      <= rd_ptr + ADDR_W'(rd_acc);
      count       <= count + (ADDR_W+1)'(wr_acc) - (ADDR_W+1)'(rd_acc);
      f.wr_ack    <= wr_acc;
      f.overflow  <= wr_req && f.full;
      f.underflow <= rd_req && f.empty;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_acc)
      mem[wr_ptr] <= f.din;
  end
`ifdef SYNC_FIFO_FWFT_EN
  assign f.dout = mem[rd_ptr];
  assign f.valid = !f.empty;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      f.dout  <= '0;
      f.valid <= 1'b0;
    end else begin
      f.valid <= rd_acc;
      f.dout  <= rd_acc ? mem[rd_ptr] : f.dout;
    end
  end
`endif
endmodule
